// File: rtl/ext_alu_seq_if.sv
// ----------------------------------------------------------------------------
// ext_alu_seq_if
//   Bundles the ID/EX issue signals, the ALU operand/result bus and the EX/DM
//   result bus seen by the extended-ALU issue sequencer.
//
//   Issue side (from ID/EX)  : start, func_in[2:0], src1_in[31:0], src0_in[31:0],
//                              flush
//   ALU side                 : alu_src1/alu_src0[31:0], alu_func[2:0] (to ALU)
//                              alu_dst[31:0], alu_ov, alu_zr, alu_neg (from ALU)
//   Result side (to EX/DM)   : stall_ID, res_vld, dst_EX_DM[31:0], ov, zr, neg,
//                              illegal
//
//   modport slave  : the sequencer
//   modport master : the surrounding pipeline / ALU (or a testbench)
// ----------------------------------------------------------------------------
interface ext_alu_seq_if;
  logic        start;
  logic [2:0]  func_in;
  logic [31:0] src1_in;
  logic [31:0] src0_in;
  logic        flush;

  logic [31:0] alu_src1;
  logic [31:0] alu_src0;
  logic [2:0]  alu_func;
  logic [31:0] alu_dst;
  logic        alu_ov;
  logic        alu_zr;
  logic        alu_neg;

  logic        stall_ID;
  logic        res_vld;
  logic [31:0] dst_EX_DM;
  logic        ov;
  logic        zr;
  logic        neg;
  logic        illegal;

  modport slave (
    input  start, func_in, src1_in, src0_in, flush,
    input  alu_dst, alu_ov, alu_zr, alu_neg,
    output alu_src1, alu_src0, alu_func,
    output stall_ID, res_vld, dst_EX_DM, ov, zr, neg, illegal
  );

  modport master (
    output start, func_in, src1_in, src0_in, flush,
    output alu_dst, alu_ov, alu_zr, alu_neg,
    input  alu_src1, alu_src0, alu_func,
    input  stall_ID, res_vld, dst_EX_DM, ov, zr, neg, illegal
  );
endinterface

// File: rtl/ext_alu_seq.sv
// ----------------------------------------------------------------------------
// ext_alu_seq
//   Issue sequencer in front of the multi-cycle extended ALU (EX stage).
//   Latches one op (operands + func) from ID/EX, holds it stable at the ALU
//   for the op's latency while stalling ID, then registers the ALU result and
//   flags onto the EX/DM bus with a one-cycle res_vld pulse.
//
//   Ports
//     clk    : single clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : ext_alu_seq_if.slave (issue, ALU and result signals)
//
//   Parameters LAT_* : ALU latency in cycles per func (minimum 1).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | nothing in flight, ready to accept
//   EXEC  | op held at ALU, cnt counts down to the capture edge, ID stalled
//   DONE  | result registered, res_vld high; may accept the next op
// ----------------------------------------------------------------------------
module ext_alu_seq #(
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned LAT_UMUL = 2,
  parameter int unsigned LAT_ADDF = 3,
  parameter int unsigned LAT_SUBF = 3,
  parameter int unsigned LAT_MULF = 3,
  parameter int unsigned LAT_ITF  = 2,
  parameter int unsigned LAT_FTI  = 2
) (
  input logic          clk,
  input logic          rst_n,
  ext_alu_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned CW = 8;

  localparam logic [2:0] F_MUL  = 3'b000;
  localparam logic [2:0] F_UMUL = 3'b001;
  localparam logic [2:0] F_ADDF = 3'b010;
  localparam logic [2:0] F_SUBF = 3'b011;
  localparam logic [2:0] F_MULF = 3'b100;
  localparam logic [2:0] F_ITF  = 3'b101;
  localparam logic [2:0] F_FTI  = 3'b110;
  localparam logic [2:0] F_ILL  = 3'b111;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat_m1;
  logic          accept;

  // Counter load value: the capture happens on the edge where cnt reaches 0,
  // so an op of latency L spends exactly L cycles in EXEC.
  always_comb begin
    lat_m1 = '0;
    case (bus.func_in)
      F_MUL:   lat_m1 = CW'(LAT_MUL  - 32'd1);
      F_UMUL:  lat_m1 = CW'(LAT_UMUL - 32'd1);
      F_ADDF:  lat_m1 = CW'(LAT_ADDF - 32'd1);
      F_SUBF:  lat_m1 = CW'(LAT_SUBF - 32'd1);
      F_MULF:  lat_m1 = CW'(LAT_MULF - 32'd1);
      F_ITF:   lat_m1 = CW'(LAT_ITF  - 32'd1);
      F_FTI:   lat_m1 = CW'(LAT_FTI  - 32'd1);
      default: lat_m1 = '0;
    endcase
  end

  assign accept = bus.start && !bus.flush &&
                  ((state == S_IDLE) || (state == S_DONE));

  assign bus.stall_ID = (state == S_EXEC);
  // Decoded from registered state, so a flush seen during DONE cannot
  // retract the pulse already on the bus.
  assign bus.res_vld  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.alu_src1  <= '0;
      bus.alu_src0  <= '0;
      bus.alu_func  <= F_MUL;
      bus.dst_EX_DM <= '0;
      bus.ov        <= 1'b0;
      bus.zr        <= 1'b0;
      bus.neg       <= 1'b0;
      bus.illegal   <= 1'b0;
    end else if (bus.flush) begin
      // Kill whatever is in flight; result registers keep their last value.
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            bus.alu_src1 <= bus.src1_in;
            bus.alu_src0 <= bus.src0_in;
            bus.alu_func <= bus.func_in;
            if (bus.func_in == F_ILL) begin
              // No ALU pass: report immediately with a zeroed result.
              state         <= S_DONE;
              cnt           <= '0;
              bus.dst_EX_DM <= '0;
              bus.ov        <= 1'b0;
              bus.zr        <= 1'b0;
              bus.neg       <= 1'b0;
              bus.illegal   <= 1'b1;
            end else begin
              state <= S_EXEC;
              cnt   <= lat_m1;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_EXEC: begin
          if (cnt == '0) begin
            state         <= S_DONE;
            bus.dst_EX_DM <= bus.alu_dst;
            bus.ov        <= bus.alu_ov;
            bus.zr        <= bus.alu_zr;
            bus.neg       <= bus.alu_neg;
            bus.illegal   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_ext_alu_seq
//   Testbench for ext_alu_seq. A behavioural ALU stand-in drives alu_dst and
//   flags from the registered ALU inputs; the expected result timing and
//   values come from per-func latency and result rules.
// ----------------------------------------------------------------------------
module tb_ext_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] last_dst = '0;

  ext_alu_seq_if bus ();

  ext_alu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  // Latency in cycles for each func; 0 means no ALU pass (illegal).
  function automatic int unsigned lat_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd1:       return 2;
      3'd2, 3'd3, 3'd4: return 3;
      3'd5, 3'd6:       return 2;
      default:          return 0;
    endcase
  endfunction

  // Stand-in ALU: integer ops computed exactly, float ops by fixed rules with
  // the directed cases returning their true IEEE results.
  function automatic logic [31:0] alu_model(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    case (f)
      3'd0: begin ps = longint'($signed(a)) * longint'($signed(b)); return ps[31:0]; end
      3'd1: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'd2: return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      3'd3: return a - b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return (a == 32'h40490FDB) ? 32'd3 : (a >> 8);
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    bus.alu_dst = alu_model(bus.alu_func, bus.alu_src1, bus.alu_src0);
    bus.alu_zr  = (bus.alu_dst == 32'h0);
    bus.alu_neg = bus.alu_dst[31];
    bus.alu_ov  = ^bus.alu_dst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op (caller is just past a negedge in IDLE or DONE) and follow it
  // to its DONE cycle. With noise set, ID keeps start high with junk during EXEC.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit noise);
    int unsigned lat;
    logic [31:0] e;
    bit          ill;
    lat = lat_of(f);
    ill = (f == 3'b111);
    e   = ill ? 32'h0 : alu_model(f, a, b);
    bus.start = 1'b1; bus.func_in = f; bus.src1_in = a; bus.src0_in = b;
    @(negedge clk);
    for (int i = 0; i < int'(lat); i++) begin
      chk("stall_exec", {31'b0, bus.stall_ID}, 32'd1);
      chk("vld_exec", {31'b0, bus.res_vld}, 32'd0);
      chk("alu_func_hold", {29'b0, bus.alu_func}, {29'b0, f});
      chk("alu_src1_hold", bus.alu_src1, a);
      chk("alu_src0_hold", bus.alu_src0, b);
      if (noise) begin
        bus.start = 1'b1; bus.func_in = 3'($urandom);
        bus.src1_in = $urandom; bus.src0_in = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    chk("res_vld", {31'b0, bus.res_vld}, 32'd1);
    chk("stall_done", {31'b0, bus.stall_ID}, 32'd0);
    chk("dst", bus.dst_EX_DM, e);
    chk("zr", {31'b0, bus.zr}, {31'b0, !ill && (e == 32'h0)});
    chk("neg", {31'b0, bus.neg}, {31'b0, !ill && e[31]});
    chk("ov", {31'b0, bus.ov}, {31'b0, !ill && (^e)});
    chk("illegal", {31'b0, bus.illegal}, {31'b0, ill});
    last_dst = e;
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("vld_idle", {31'b0, bus.res_vld}, 32'd0);
      chk("stall_idle", {31'b0, bus.stall_ID}, 32'd0);
      chk("dst_hold", bus.dst_EX_DM, last_dst);
    end
  endtask

  // Issue an op and flush it during EXEC cycle k (1..LAT).
  task automatic flush_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int k);
    bus.start = 1'b1; bus.func_in = f; bus.src1_in = a; bus.src0_in = b;
    @(negedge clk);
    for (int i = 1; i <= k; i++) begin
      chk("stall_pre_flush", {31'b0, bus.stall_ID}, 32'd1);
      bus.start = 1'b0;
      if (i == k) bus.flush = 1'b1;
      @(negedge clk);
    end
    bus.flush = 1'b0;
    chk("stall_post_flush", {31'b0, bus.stall_ID}, 32'd0);
    chk("vld_post_flush", {31'b0, bus.res_vld}, 32'd0);
    chk("dst_post_flush", bus.dst_EX_DM, last_dst);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    bus.start = 1'b0; bus.flush = 1'b0; bus.func_in = 3'b0;
    bus.src1_in = '0; bus.src0_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_vld", {31'b0, bus.res_vld}, 32'd0);
    chk("rst_stall", {31'b0, bus.stall_ID}, 32'd0);
    chk("rst_dst", bus.dst_EX_DM, 32'd0);
    chk("rst_alu_func", {29'b0, bus.alu_func}, 32'd0);
    chk("rst_alu_src1", bus.alu_src1, 32'd0);
    chk("rst_flags", {28'b0, bus.ov, bus.zr, bus.neg, bus.illegal}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // ADDF 1.0 + 2.0
    run_op(3'b010, 32'h3F800000, 32'h40000000, 1'b0);
    chk("addf_const", bus.dst_EX_DM, 32'h40400000);
    idle(1);

    // Back-to-back MUL(7,-3) then UMUL(5,5), start held throughout
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 1'b1);
    chk("mul_const", bus.dst_EX_DM, 32'hFFFFFFEB);
    run_op(3'b001, 32'd5, 32'd5, 1'b1);
    chk("umul_const", bus.dst_EX_DM, 32'h00000019);
    idle(1);

    // Illegal func
    run_op(3'b111, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    chk("illegal_const", {31'b0, bus.illegal}, 32'd1);
    idle(1);

    // Flush in 2nd EXEC cycle of MULF, prior result must survive
    run_op(3'b001, 32'd3, 32'd4, 1'b0);
    idle(1);
    flush_op(3'b100, 32'h40000000, 32'h40400000, 2);
    chk("flush_keep_const", bus.dst_EX_DM, 32'd12);
    idle(2);

    // Flush wins over simultaneous start
    bus.start = 1'b1; bus.flush = 1'b1; bus.func_in = 3'b000;
    bus.src1_in = 32'd9; bus.src0_in = 32'd9;
    @(negedge clk);
    chk("flush_vs_start_stall", {31'b0, bus.stall_ID}, 32'd0);
    chk("flush_vs_start_vld", {31'b0, bus.res_vld}, 32'd0);
    bus.flush = 1'b0;
    idle(1);

    // Flush during DONE keeps the current pulse, then goes IDLE
    run_op(3'b000, 32'd2, 32'd3, 1'b0);
    bus.flush = 1'b1; bus.start = 1'b1;
    #1;
    chk("flush_done_vld", {31'b0, bus.res_vld}, 32'd1);
    @(negedge clk);
    chk("flush_done_next_vld", {31'b0, bus.res_vld}, 32'd0);
    chk("flush_done_next_stall", {31'b0, bus.stall_ID}, 32'd0);
    chk("flush_done_dst", bus.dst_EX_DM, 32'd6);
    bus.flush = 1'b0;
    idle(1);

    // Async reset mid-EXEC
    bus.start = 1'b1; bus.func_in = 3'b100; bus.src1_in = 32'hDEAD0001; bus.src0_in = 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_stall", {31'b0, bus.stall_ID}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stall", {31'b0, bus.stall_ID}, 32'd0);
    chk("arst_vld", {31'b0, bus.res_vld}, 32'd0);
    chk("arst_dst", bus.dst_EX_DM, 32'd0);
    chk("arst_alu_src1", bus.alu_src1, 32'd0);
    chk("arst_alu_func", {29'b0, bus.alu_func}, 32'd0);
    chk("arst_flags", {28'b0, bus.ov, bus.zr, bus.neg, bus.illegal}, 32'd0);
    last_dst = 32'h0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    idle(1);
    run_op(3'b110, 32'h40490FDB, 32'h0, 1'b0);
    chk("fti_const", bus.dst_EX_DM, 32'd3);
    idle(1);

    // SUBF equal operands -> zero flag, flags hold after the pulse
    a = $urandom;
    run_op(3'b011, a, a, 1'b0);
    chk("subf_zr_const", {31'b0, bus.zr}, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("zr_hold", {31'b0, bus.zr}, 32'd1);
    chk("zr_hold_vld", {31'b0, bus.res_vld}, 32'd0);
    idle(1);

    // Randomized mix: back-to-back, gaps, junk during EXEC, flushes
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (f != 3'b111 && $urandom_range(0, 4) == 0) begin
        flush_op(f, a, b, int'($urandom_range(1, lat_of(f))));
      end else begin
        run_op(f, a, b, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
